assert_fail_monitor: RTL and testbench
======================================

ASSERT_FAIL_MONITOR -- requirements
Module: assert_fail_monitor

Interface
REQ-001 Parameters SHALL be:
- NUM_CH, 4, number of independent check channels (1..32).
- CNT_W, 8, width of each per-channel failure counter.
- TS_W, 16, width of the timestamp counter.
- MAX_REPORT, 2, reports emitted per channel before suppression; 0 = unlimited.
REQ-002 Ports SHALL be (CH_W = max(1,$clog2(NUM_CH))):
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- chk_valid  in  NUM_CH  channel i check evaluated this cycle.
- chk_flag  in  NUM_CH  check result, 1 = pass.
- ch_en  in  NUM_CH  channel enable; disabled channels ignore checks entirely.
- clr  in  1  synchronous clear pulse.
- fail_cnt  out  NUM_CH*CNT_W  per-channel failure counts, channel i at bits [i*CNT_W +: CNT_W].
- report_valid  out  1  report available.
- report_ready  in  1  consumer accepts report.
- report_ch  out  CH_W  failing channel of current report.
- report_ts  out  TS_W  timestamp of that failure.
- first_fail_vld  out  1  a failure has been captured since reset/clr.
- first_fail_ch  out  CH_W  channel of first failure.
- first_fail_ts  out  TS_W  timestamp of first failure.
- overflow  out  1  sticky: at least one eligible report was dropped.
- irq  out  1  equals first_fail_vld | overflow.

Function
REQ-003 A failure on channel i at edge E SHALL be chk_valid[i] & ch_en[i] & ~chk_flag[i], sampled at E.
REQ-004 ts SHALL be a free-running TS_W counter, 0 after reset, +1 every cycle, wrapping to 0; the timestamp of a failure at edge E SHALL be ts value before E; clr SHALL NOT affect ts.
REQ-005 Each failure SHALL increment fail_cnt[i] by 1, saturating at 2^CNT_W-1.
REQ-006 Per channel a report-count rpt[i] SHALL exist; a failure is eligible when MAX_REPORT==0 or rpt[i] < MAX_REPORT; rpt[i] increments (saturating) on every eligible failure, whether queued or dropped.
REQ-007 Per channel a single pending slot (pend[i], pend_ts[i]) SHALL exist; an eligible failure sets pend[i] and pend_ts[i] at E.
REQ-008 An eligible failure on a channel whose pend[i] is set and not being transferred to the output at E SHALL be dropped, set overflow; fail_cnt and rpt still update.
REQ-009 Ineligible (suppressed) failures SHALL update only fail_cnt; no report, no overflow.
REQ-010 Output register: when report_valid==0, or report_valid&report_ready at an edge, it SHALL load the lowest-index pending channel (report_ch, report_ts), clear that pend bit, and set report_valid; if none pending, report_valid deasserts.
REQ-011 report_ch/report_ts SHALL remain stable while report_valid & ~report_ready.
REQ-012 Latency: failure at edge E with idle output SHALL give report_valid=1 after edge E+1 (2 cycles from sampling).
REQ-013 A pend slot transferred to output at E SHALL accept a new eligible failure on the same channel at E without overflow.
REQ-014 First failure after reset/clr SHALL latch first_fail_vld=1, ch, ts; simultaneous failures latch lowest index; later failures do not alter it; captured regardless of eligibility.
REQ-015 clr at E SHALL zero fail_cnt, rpt, pend, output register (report_valid=0), first_fail_*, overflow; failures sampled at E SHALL be ignored (clr wins).

Reset
REQ-016 rst_n low SHALL asynchronously force: ts=0, fail_cnt=0, rpt=0, pend=0, report_valid=0, report_ch=0, report_ts=0, first_fail_vld=0, first_fail_ch=0, first_fail_ts=0, overflow=0, irq=0; reset mid-handshake discards the report.
REQ-017 Deassertion SHALL be synchronised; first sampled edge after release has ts=0.

Verification
REQ-018 Single failure: ch2 fails at ts=5, ready=1 -> report_valid 2 cycles later, report_ch=2, report_ts=5, fail_cnt[2]=1, first_fail_ch=2, ts=5, irq=1.
REQ-019 Suppression: ch0 fails 5 times, MAX_REPORT=2, ready=1 -> exactly 2 reports, fail_cnt[0]=5, overflow=0.
REQ-020 Simultaneous/backpressure: ch1 and ch3 fail same edge, ready=0 for 4 cycles -> report_ch=1 held stable, then ch3 delivered next; first_fail_ch=1.
REQ-021 Overflow: ready=0, ch0 fails twice (MAX_REPORT=0) -> second dropped, overflow=1, fail_cnt[0]=2; ch_en[0]=0 failures -> no count change.
REQ-022 Saturation/wrap: CNT_W=2, 6 failures -> fail_cnt=3; ts wraps 2^TS_W-1 -> 0 with correct report_ts.
REQ-023 clr coincident with ch1 failure -> all state zero, no report, fail_cnt[1]=0; rst_n low mid-report -> report_valid=0 immediately.

Source files
------------

// File: rtl/assert_fail_monitor.sv
// Assertion failure monitor: per-channel saturating fail counters, rate-limited reports
// through one pending slot per channel, first-failure capture and a sticky overflow flag.
module assert_fail_monitor #(
  parameter  int NUM_CH     = 4,
  parameter  int CNT_W      = 8,
  parameter  int TS_W       = 16,
  parameter  int MAX_REPORT = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       chk_valid,
  input  logic [NUM_CH-1:0]       chk_flag,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    clr,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt,
  output logic                    report_valid,
  input  logic                    report_ready,
  output logic [CH_W-1:0]         report_ch,
  output logic [TS_W-1:0]         report_ts,
  output logic                    first_fail_vld,
  output logic [CH_W-1:0]         first_fail_ch,
  output logic [TS_W-1:0]         first_fail_ts,
  output logic                    overflow,
  output logic                    irq
);

  localparam int RPT_W = (MAX_REPORT > 0) ? $clog2(MAX_REPORT + 1) : 1;

  logic [1:0]                        rst_sync_q;
  logic [TS_W-1:0]                   ts_q, ts_d;
  logic [NUM_CH-1:0][CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_CH-1:0][RPT_W-1:0]      rpt_q, rpt_d;
  logic [NUM_CH-1:0]                 pend_q, pend_d;
  logic [NUM_CH-1:0][TS_W-1:0]       pend_ts_q, pend_ts_d;
  logic                              rv_q, rv_d;
  logic [CH_W-1:0]                   rch_q, rch_d;
  logic [TS_W-1:0]                   rts_q, rts_d;
  logic                              ffv_q, ffv_d;
  logic [CH_W-1:0]                   ffc_q, ffc_d;
  logic [TS_W-1:0]                   fft_q, fft_d;
  logic                              ovf_q, ovf_d;

  logic [NUM_CH-1:0]                 fail;
  logic [NUM_CH-1:0]                 xfer_oh;
  logic [CH_W-1:0]                   xfer_ch;
  logic [TS_W-1:0]                   xfer_ts;
  logic                              load;
  logic                              elig;

  // Reset asserts asynchronously but releases two edges later, so ts starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  always_comb begin
    ts_d      = ts_q + 1'b1;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    pend_ts_d = pend_ts_q;
    rv_d      = rv_q;
    rch_d     = rch_q;
    rts_d     = rts_q;
    ffv_d     = ffv_q;
    ffc_d     = ffc_q;
    fft_d     = fft_q;
    ovf_d     = ovf_q;
    xfer_oh   = '0;
    xfer_ch   = '0;
    xfer_ts   = '0;
    elig      = 1'b0;
    load      = ~rv_q | report_ready;
    fail      = chk_valid & ch_en & ~chk_flag;

    if (load) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (pend_q[i]) begin
          xfer_oh    = '0;
          xfer_oh[i] = 1'b1;
          xfer_ch    = CH_W'(i);
          xfer_ts    = pend_ts_q[i];
        end
      end
      rv_d = |xfer_oh;
      if (|xfer_oh) begin
        rch_d = xfer_ch;
        rts_d = xfer_ts;
      end
    end
    pend_d = pend_q & ~xfer_oh;

    // A slot freed by this edge's transfer can take a new failure without overflow.
    for (int i = 0; i < NUM_CH; i++) begin
      if (fail[i]) begin
        if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
        elig = (MAX_REPORT == 0) || (int'(rpt_q[i]) < MAX_REPORT);
        if (elig) begin
          if (rpt_q[i] != '1) rpt_d[i] = rpt_q[i] + 1'b1;
          if (pend_d[i]) begin
            ovf_d = 1'b1;
          end else begin
            pend_d[i]    = 1'b1;
            pend_ts_d[i] = ts_q;
          end
        end
      end
    end

    if (!ffv_q) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (fail[i]) begin
          ffv_d = 1'b1;
          ffc_d = CH_W'(i);
          fft_d = ts_q;
        end
      end
    end

    if (clr || !rst_sync_q[1]) begin
      cnt_d     = '0;
      rpt_d     = '0;
      pend_d    = '0;
      pend_ts_d = '0;
      rv_d      = 1'b0;
      rch_d     = '0;
      rts_d     = '0;
      ffv_d     = 1'b0;
      ffc_d     = '0;
      fft_d     = '0;
      ovf_d     = 1'b0;
    end
    if (!rst_sync_q[1]) ts_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q      <= '0;
      cnt_q     <= '0;
      rpt_q     <= '0;
      pend_q    <= '0;
      pend_ts_q <= '0;
      rv_q      <= 1'b0;
      rch_q     <= '0;
      rts_q     <= '0;
      ffv_q     <= 1'b0;
      ffc_q     <= '0;
      fft_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      cnt_q     <= cnt_d;
      rpt_q     <= rpt_d;
      pend_q    <= pend_d;
      pend_ts_q <= pend_ts_d;
      rv_q      <= rv_d;
      rch_q     <= rch_d;
      rts_q     <= rts_d;
      ffv_q     <= ffv_d;
      ffc_q     <= ffc_d;
      fft_q     <= fft_d;
      ovf_q     <= ovf_d;
    end
  end

  assign fail_cnt       = cnt_q;
  assign report_valid   = rv_q;
  assign report_ch      = rch_q;
  assign report_ts      = rts_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_ch  = ffc_q;
  assign first_fail_ts  = fft_q;
  assign overflow       = ovf_q;
  assign irq            = ffv_q | ovf_q;

endmodule

// File: tb/tb_assert_fail_monitor.sv
// Bench for assert_fail_monitor: directed scenarios plus random traffic against a
// behavioural model that tracks per-channel slots, counters and the report register.
module tb_assert_fail_monitor;
  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 3;
  localparam int TS_W       = 6;
  localparam int MAX_REPORT = 2;
  localparam int CH_W       = 2;
  localparam int TS_MOD     = 1 << TS_W;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH-1:0] chk_valid = '0;
  logic [NUM_CH-1:0] chk_flag = '1;
  logic [NUM_CH-1:0] ch_en = '1;
  logic clr = 1'b0;
  logic report_ready = 1'b1;
  logic [NUM_CH*CNT_W-1:0] fail_cnt;
  logic report_valid;
  logic [CH_W-1:0] report_ch;
  logic [TS_W-1:0] report_ts;
  logic first_fail_vld;
  logic [CH_W-1:0] first_fail_ch;
  logic [TS_W-1:0] first_fail_ts;
  logic overflow;
  logic irq;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assert_fail_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TS_W(TS_W), .MAX_REPORT(MAX_REPORT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chk_valid(chk_valid), .chk_flag(chk_flag),
    .ch_en(ch_en), .clr(clr), .fail_cnt(fail_cnt), .report_valid(report_valid),
    .report_ready(report_ready), .report_ch(report_ch), .report_ts(report_ts),
    .first_fail_vld(first_fail_vld), .first_fail_ch(first_fail_ch),
    .first_fail_ts(first_fail_ts), .overflow(overflow), .irq(irq)
  );

  // Reference model
  int m_rel = 0;
  int m_ts = 0;
  int m_cnt[NUM_CH];
  int m_rpt[NUM_CH];
  bit m_pend[NUM_CH];
  int m_pts[NUM_CH];
  bit m_rv = 0;
  int m_rch = 0;
  int m_rts = 0;
  bit m_ffv = 0;
  int m_ffc = 0;
  int m_fft = 0;
  bit m_ovf = 0;
  int m_pick;
  int hs_cnt[NUM_CH];

  task automatic m_zero();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_rpt[i] = 0; m_pend[i] = 0; m_pts[i] = 0;
    end
    m_rv = 0; m_rch = 0; m_rts = 0;
    m_ffv = 0; m_ffc = 0; m_fft = 0; m_ovf = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rel = 0;
      m_ts = 0;
      m_zero();
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      if (clr) begin
        m_zero();
      end else begin
        if (!m_rv || report_ready) begin
          m_pick = -1;
          for (int i = NUM_CH - 1; i >= 0; i--) if (m_pend[i]) m_pick = i;
          if (m_pick >= 0) begin
            m_rv = 1; m_rch = m_pick; m_rts = m_pts[m_pick]; m_pend[m_pick] = 0;
          end else begin
            m_rv = 0;
          end
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (chk_valid[i] && ch_en[i] && !chk_flag[i]) begin
            if (!m_ffv) begin m_ffv = 1; m_ffc = i; m_fft = m_ts; end
            if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
            if (MAX_REPORT == 0 || m_rpt[i] < MAX_REPORT) begin
              m_rpt[i]++;
              if (m_pend[i]) m_ovf = 1;
              else begin m_pend[i] = 1; m_pts[i] = m_ts; end
            end
          end
        end
      end
      m_ts = (m_ts + 1) % TS_MOD;
    end
  end

  always @(posedge clk)
    if (rst_n && report_valid && report_ready) hs_cnt[report_ch] = hs_cnt[report_ch] + 1;

  function automatic int cnt_of(int ch);
    return int'(fail_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic idle();
    chk_valid = '0; chk_flag = '1; clr = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; idle(); ch_en = '1; report_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clr_pulse();
    @(negedge clk); idle(); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    repeat (3) @(negedge clk);
    n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", report_valid); end
    n_checks++; if (fail_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0h expected 0", fail_cnt); end
    n_checks++; if ({first_fail_vld, first_fail_ch, first_fail_ts} !== '0) begin n_fail++; $display("FAIL rst_first: got %0b/%0d/%0d expected 0", first_fail_vld, first_fail_ch, first_fail_ts); end
    n_checks++; if ({overflow, irq, report_ch, report_ts} !== '0) begin n_fail++; $display("FAIL rst_misc: got ovf=%0b irq=%0b ch=%0d ts=%0d expected 0", overflow, irq, report_ch, report_ts); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int k;
    apply_reset();
    k = 0;
    while (m_ts != 5 && k < 4 * TS_MOD) begin @(negedge clk); k++; end
    n_checks++; if (m_ts != 5) begin n_fail++; $display("FAIL single_wait: got ts %0d expected 5", m_ts); end
    chk_valid = 4'b0100; chk_flag = '0; report_ready = 1'b1;
    @(negedge clk); idle();
    n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got valid %0b expected 0", report_valid); end
    n_checks++; if (cnt_of(2) != 1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", cnt_of(2)); end
    n_checks++; if ({first_fail_vld, first_fail_ch, first_fail_ts, irq} !== {1'b1, 2'd2, 6'd5, 1'b1}) begin n_fail++; $display("FAIL single_first: got vld=%0b ch=%0d ts=%0d irq=%0b expected 1/2/5/1", first_fail_vld, first_fail_ch, first_fail_ts, irq); end
    @(negedge clk);
    n_checks++; if ({report_valid, report_ch, report_ts} !== {1'b1, 2'd2, 6'd5}) begin n_fail++; $display("FAIL single_report: got v=%0b ch=%0d ts=%0d expected 1/2/5", report_valid, report_ch, report_ts); end
  endtask

  task automatic test_suppress();
    int h0;
    clr_pulse(); report_ready = 1'b1;
    h0 = hs_cnt[0];
    for (int i = 0; i < 5; i++) begin
      chk_valid = 4'b0001; chk_flag = '0;
      @(negedge clk);
    end
    idle();
    repeat (6) @(negedge clk);
    n_checks++; if (hs_cnt[0] - h0 != 2) begin n_fail++; $display("FAIL suppress_reports: got %0d expected 2", hs_cnt[0] - h0); end
    n_checks++; if (cnt_of(0) != 5) begin n_fail++; $display("FAIL suppress_cnt: got %0d expected 5", cnt_of(0)); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL suppress_ovf: got %0b expected 0", overflow); end
  endtask

  task automatic test_backpressure();
    int ts_e;
    clr_pulse();
    report_ready = 1'b0;
    chk_valid = 4'b1010; chk_flag = '0; ts_e = m_ts;
    @(negedge clk); idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if ({report_valid, report_ch, report_ts} !== {1'b1, 2'd1, TS_W'(ts_e)}) begin n_fail++; $display("FAIL bp_hold%0d: got v=%0b ch=%0d ts=%0d expected 1/1/%0d", i, report_valid, report_ch, report_ts, ts_e); end
    end
    report_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({report_valid, report_ch, report_ts} !== {1'b1, 2'd3, TS_W'(ts_e)}) begin n_fail++; $display("FAIL bp_second: got v=%0b ch=%0d ts=%0d expected 1/3/%0d", report_valid, report_ch, report_ts, ts_e); end
    n_checks++; if (first_fail_ch !== 2'd1) begin n_fail++; $display("FAIL bp_first_ch: got %0d expected 1", first_fail_ch); end
    @(negedge clk);
    n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b expected 0", report_valid); end
  endtask

  task automatic test_overflow();
    clr_pulse();
    report_ready = 1'b0;
    chk_valid = 4'b0010; chk_flag = '0;
    @(negedge clk); chk_valid = 4'b0001;
    @(negedge clk); chk_valid = 4'b0001;
    @(negedge clk); idle();
    n_checks++; if ({overflow, irq} !== 2'b11) begin n_fail++; $display("FAIL ovf_flag: got ovf=%0b irq=%0b expected 1/1", overflow, irq); end
    n_checks++; if (cnt_of(0) != 2) begin n_fail++; $display("FAIL ovf_cnt: got %0d expected 2", cnt_of(0)); end
    ch_en = 4'b1110; chk_valid = 4'b0001; chk_flag = '0;
    repeat (3) @(negedge clk);
    idle(); ch_en = '1;
    @(negedge clk);
    n_checks++; if (cnt_of(0) != 2) begin n_fail++; $display("FAIL ovf_disabled_cnt: got %0d expected 2", cnt_of(0)); end
    report_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_saturation();
    clr_pulse(); report_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_valid = 4'b0100; chk_flag = '0;
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    n_checks++; if (cnt_of(2) != CNT_MAX) begin n_fail++; $display("FAIL sat_cnt: got %0d expected %0d", cnt_of(2), CNT_MAX); end
    n_checks++; if (cnt_of(0) + cnt_of(1) + cnt_of(3) != 0) begin n_fail++; $display("FAIL sat_others: got %0h expected 0", fail_cnt); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ts_wrap();
    int k;
    clr_pulse(); report_ready = 1'b1;
    k = 0;
    while (m_ts != TS_MOD - 1 && k < 2 * TS_MOD) begin @(negedge clk); k++; end
    n_checks++; if (m_ts != TS_MOD - 1) begin n_fail++; $display("FAIL wrap_wait: got ts %0d expected %0d", m_ts, TS_MOD - 1); end
    chk_valid = 4'b1000; chk_flag = '0;
    @(negedge clk);
    @(negedge clk); idle();
    n_checks++; if ({report_valid, report_ch, report_ts} !== {1'b1, 2'd3, TS_W'(TS_MOD - 1)}) begin n_fail++; $display("FAIL wrap_last: got v=%0b ch=%0d ts=%0d expected 1/3/%0d", report_valid, report_ch, report_ts, TS_MOD - 1); end
    @(negedge clk);
    n_checks++; if ({report_valid, report_ch, report_ts} !== {1'b1, 2'd3, TS_W'(0)}) begin n_fail++; $display("FAIL wrap_zero: got v=%0b ch=%0d ts=%0d expected 1/3/0", report_valid, report_ch, report_ts); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clr();
    clr_pulse(); report_ready = 1'b0;
    chk_valid = 4'b0101; chk_flag = '0;
    @(negedge clk); idle();
    repeat (2) @(negedge clk);
    n_checks++; if (report_valid !== 1'b1) begin n_fail++; $display("FAIL clr_pre: got valid %0b expected 1", report_valid); end
    clr = 1'b1; chk_valid = 4'b0010; chk_flag = '0;
    @(negedge clk); idle();
    n_checks++; if ({report_valid, report_ch, report_ts} !== '0) begin n_fail++; $display("FAIL clr_report: got v=%0b ch=%0d ts=%0d expected 0", report_valid, report_ch, report_ts); end
    n_checks++; if (fail_cnt !== '0) begin n_fail++; $display("FAIL clr_cnt: got %0h expected 0", fail_cnt); end
    n_checks++; if ({first_fail_vld, overflow, irq} !== 3'b000) begin n_fail++; $display("FAIL clr_flags: got ffv=%0b ovf=%0b irq=%0b expected 0", first_fail_vld, overflow, irq); end
    report_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (report_valid !== 1'b0 || cnt_of(1) != 0) begin n_fail++; $display("FAIL clr_after: got v=%0b cnt1=%0d expected 0/0", report_valid, cnt_of(1)); end
  endtask

  task automatic test_reset_mid();
    report_ready = 1'b0;
    chk_valid = 4'b0010; chk_flag = '0;
    @(negedge clk); idle();
    @(negedge clk);
    n_checks++; if (report_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %0b expected 1", report_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({report_valid, irq, overflow} !== 3'b000 || fail_cnt !== '0) begin n_fail++; $display("FAIL rmid_async: got v=%0b irq=%0b ovf=%0b cnt=%0h expected 0", report_valid, irq, overflow, fail_cnt); end
    @(negedge clk);
    rst_n = 1'b1; report_ready = 1'b1;
  endtask

  task automatic test_random();
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      n_checks++; if (report_valid !== m_rv) begin n_fail++; $display("FAIL rnd_valid c%0d: got %0b expected %0b", c, report_valid, m_rv); end
      n_checks++; if (report_ch !== CH_W'(m_rch) || report_ts !== TS_W'(m_rts)) begin n_fail++; $display("FAIL rnd_report c%0d: got ch=%0d ts=%0d expected ch=%0d ts=%0d", c, report_ch, report_ts, m_rch, m_rts); end
      for (int i = 0; i < NUM_CH; i++) begin
        n_checks++; if (cnt_of(i) != m_cnt[i]) begin n_fail++; $display("FAIL rnd_cnt%0d c%0d: got %0d expected %0d", i, c, cnt_of(i), m_cnt[i]); end
      end
      n_checks++; if (first_fail_vld !== m_ffv || first_fail_ch !== CH_W'(m_ffc) || first_fail_ts !== TS_W'(m_fft)) begin n_fail++; $display("FAIL rnd_first c%0d: got %0b/%0d/%0d expected %0b/%0d/%0d", c, first_fail_vld, first_fail_ch, first_fail_ts, m_ffv, m_ffc, m_fft); end
      n_checks++; if (overflow !== m_ovf || irq !== (m_ffv | m_ovf)) begin n_fail++; $display("FAIL rnd_ovf_irq c%0d: got %0b/%0b expected %0b/%0b", c, overflow, irq, m_ovf, m_ffv | m_ovf); end
      chk_valid = NUM_CH'($urandom);
      for (int i = 0; i < NUM_CH; i++) begin
        chk_flag[i] = ($urandom_range(0, 3) != 0);
        ch_en[i]    = ($urandom_range(0, 7) != 0);
      end
      report_ready = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    idle(); ch_en = '1;
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) hs_cnt[i] = 0;
    test_reset();
    test_single();
    test_suppress();
    test_backpressure();
    test_overflow();
    test_saturation();
    test_ts_wrap();
    test_clr();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
